sync_rr_arb_merge: RTL and testbench

//   Synchronous N-to-1 arbitrated merge for the 32-bit drive/free channels: the clocked counterpart of the
//   two-input click arbiter-merge. Selects one requester per cycle by rotating priority, with optional burst

---
 rtl/sync_rr_arb_merge.sv | 134 +++++++++++++
 tb/tb_sync_rr_arb_merge.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/sync_rr_arb_merge.sv
// N-to-1 rotating-priority merge with burst lock into a one-entry registered output stage.
// Latency 1 cycle, full throughput; no o_free while the output word is held and downstream is not ready.
module sync_rr_arb_merge #(
    parameter int NUM_REQ   = 4,
    parameter int DATA_W    = 32,
    parameter int MAX_BURST = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_REQ-1:0]          i_drive,
    input  logic [NUM_REQ*DATA_W-1:0]   i_data,
    output logic [NUM_REQ-1:0]          o_free,
    output logic                        o_driveNext,
    output logic [DATA_W-1:0]           o_data,
    output logic [$clog2(NUM_REQ)-1:0]  o_grant_id,
    input  logic                        i_freeNext,
    output logic                        o_busy
);
    localparam int IDW = $clog2(NUM_REQ);
    localparam int CW  = $clog2(MAX_BURST + 1);

    typedef enum logic {ST_ARB, ST_BURST} state_t;

    state_t            state_q, state_d;
    logic [IDW-1:0]    ptr_q, ptr_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              vld_q;
    logic [DATA_W-1:0] dat_q;
    logic [IDW-1:0]    id_q;

    logic              slot_avail;
    logic              owner_req;
    logic              arb_hit;
    logic [IDW-1:0]    arb_idx;
    logic [IDW-1:0]    sel_idx;
    logic              any_req;
    logic              grant;
    logic [DATA_W-1:0] sel_dat;

    assign slot_avail = ~vld_q | i_freeNext;
    assign owner_req  = (state_q == ST_BURST) & i_drive[ptr_q];

    // Circular search starting one past the last owner.
    always_comb begin
        arb_hit = 1'b0;
        arb_idx = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            if (!arb_hit && i_drive[(int'(ptr_q) + i) % NUM_REQ]) begin
                arb_hit = 1'b1;
                arb_idx = IDW'((int'(ptr_q) + i) % NUM_REQ);
            end
        end
    end

    assign sel_idx = owner_req ? ptr_q : arb_idx;
    assign any_req = owner_req | arb_hit;
    assign grant   = slot_avail & ~rst & any_req;

    always_comb begin
        sel_dat = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (IDW'(k) == sel_idx) begin
                sel_dat = i_data[k*DATA_W +: DATA_W];
            end
        end
    end

    // FSM: state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_ARB;
            ptr_q   <= IDW'(NUM_REQ - 1);
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    // FSM: next state. Everything freezes while the output slot is blocked.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        if (slot_avail) begin
            if (!any_req) begin
                state_d = ST_ARB;
            end else if (owner_req) begin
                cnt_d = cnt_q + CW'(1);
                if (int'(cnt_q) + 1 == MAX_BURST) begin
                    state_d = ST_ARB;
                end
            end else begin
                ptr_d   = arb_idx;
                cnt_d   = CW'(1);
                state_d = (MAX_BURST > 1) ? ST_BURST : ST_ARB;
            end
        end
    end

    // FSM: outputs
    always_comb begin
        o_free = '0;
        if (grant) begin
            o_free[sel_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= 1'b0;
            dat_q <= '0;
            id_q  <= '0;
        end else if (grant) begin
            vld_q <= 1'b1;
            dat_q <= sel_dat;
            id_q  <= sel_idx;
        end else if (i_freeNext) begin
            vld_q <= 1'b0;
        end
    end

    assign o_driveNext = vld_q;
    assign o_data      = dat_q;
    assign o_grant_id  = id_q;
    assign o_busy      = (state_q == ST_BURST) | vld_q;

    for (genvar k = 0; k < NUM_REQ; k++) begin : g_chk
        a_up_stable: assert property (@(posedge clk) disable iff (rst)
            (i_drive[k] && !o_free[k]) |=> (!i_drive[k] || $stable(i_data[k*DATA_W +: DATA_W])));
    end

endmodule

// File: tb/tb_sync_rr_arb_merge.sv
// Scoreboarded directed bench: one burst-mode instance (MAX_BURST=4) and one pure round-robin instance.
module tb_sync_rr_arb_merge;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst, fr, rr_rst, rr_fr;
    logic [3:0]   drv, rr_drv;
    logic [127:0] dat;

    logic [3:0]   b_free, r_free;
    logic         b_vld, r_vld, b_busy, r_busy;
    logic [31:0]  b_data, r_data;
    logic [1:0]   b_id, r_id;

    sync_rr_arb_merge #(.NUM_REQ(4), .DATA_W(32), .MAX_BURST(4)) dut_b (
        .clk(clk), .rst(rst), .i_drive(drv), .i_data(dat), .o_free(b_free),
        .o_driveNext(b_vld), .o_data(b_data), .o_grant_id(b_id),
        .i_freeNext(fr), .o_busy(b_busy));

    sync_rr_arb_merge #(.NUM_REQ(4), .DATA_W(32), .MAX_BURST(1)) dut_rr (
        .clk(clk), .rst(rr_rst), .i_drive(rr_drv), .i_data(dat), .o_free(r_free),
        .o_driveNext(r_vld), .o_data(r_data), .o_grant_id(r_id),
        .i_freeNext(rr_fr), .o_busy(r_busy));

    typedef struct {
        logic [1:0]  id;
        logic [31:0] d;
    } exp_t;

    exp_t exp_b[$];
    exp_t exp_r[$];
    int n_tests = 0;
    int n_fail  = 0;
    int seq_a[10];
    int seq_r[5];

    function automatic logic [31:0] wd(int k);
        return 32'hA0 + k;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push_b(int k);
        exp_t e;
        e.id = 2'(k);
        e.d  = wd(k);
        exp_b.push_back(e);
    endtask

    task automatic push_r(int k);
        exp_t e;
        e.id = 2'(k);
        e.d  = wd(k);
        exp_r.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (b_vld === 1'b1 && fr === 1'b1) begin
            if (exp_b.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL b_unexpected: got id %0d data %h, expected no word", b_id, b_data);
            end else begin
                e = exp_b.pop_front();
                check("b_id", 32'(b_id), 32'(e.id));
                check("b_data", b_data, e.d);
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (r_vld === 1'b1 && rr_fr === 1'b1) begin
            if (exp_r.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL r_unexpected: got id %0d data %h, expected no word", r_id, r_data);
            end else begin
                e = exp_r.pop_front();
                check("r_id", 32'(r_id), 32'(e.id));
                check("r_data", r_data, e.d);
            end
        end
    end

    initial begin
        seq_a = '{0, 0, 0, 0, 1, 1, 1, 1, 2, 2};
        seq_r = '{0, 1, 2, 3, 0};
        for (int k = 0; k < 4; k++) dat[k*32 +: 32] = wd(k);
        rst = 1'b1; fr = 1'b1; drv = 4'hF;
        rr_rst = 1'b1; rr_fr = 1'b1; rr_drv = 4'h0;

        // Reset with all requesters asserting
        tick();
        check("rst_free", 32'(b_free), 32'h0);
        check("rst_vld", 32'(b_vld), 32'h0);
        check("rst_data", b_data, 32'h0);
        check("rst_id", 32'(b_id), 32'h0);
        check("rst_busy", 32'(b_busy), 32'h0);
        tick();
        check("rst_free2", 32'(b_free), 32'h0);

        // Bursts of four, then owner 2 drops after two grants
        rst = 1'b0;
        #1;
        for (int i = 0; i < 10; i++) begin
            check("burst_free", 32'(b_free), 32'(1 << seq_a[i]));
            push_b(seq_a[i]);
            tick();
            check("burst_vld", 32'(b_vld), 32'h1);
            if (i == 0) check("burst_busy", 32'(b_busy), 32'h1);
        end
        drv = 4'b1001;
        #1;
        check("exit_free", 32'(b_free), 32'h8);
        push_b(3);
        tick();
        check("exit_vld", 32'(b_vld), 32'h1);
        check("exit_id", 32'(b_id), 32'h3);

        // Backpressure
        fr = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            check("stall_free", 32'(b_free), 32'h0);
            check("stall_data", b_data, wd(3));
            check("stall_id", 32'(b_id), 32'h3);
            tick();
        end
        fr = 1'b1;
        #1;
        check("rel_free", 32'(b_free), 32'h8);
        push_b(3);
        tick();
        check("rel_free2", 32'(b_free), 32'h8);
        push_b(3);
        tick();

        // Reset while a word is pending: that word is lost
        rst = 1'b1;
        fr  = 1'b0;
        void'(exp_b.pop_back());
        #1;
        check("mid_rst_free", 32'(b_free), 32'h0);
        tick();
        check("mid_rst_vld", 32'(b_vld), 32'h0);
        rst = 1'b0;
        fr  = 1'b1;
        #1;
        check("post_rst_free", 32'(b_free), 32'h1);
        push_b(0);
        tick();
        drv = 4'h0;
        tick();
        tick();
        check("b_drained", 32'(exp_b.size()), 32'h0);

        // Pure round-robin instance
        rr_rst = 1'b0;
        rr_drv = 4'hF;
        #1;
        for (int i = 0; i < 5; i++) begin
            check("rr_free", 32'(r_free), 32'(1 << seq_r[i]));
            push_r(seq_r[i]);
            tick();
            check("rr_vld", 32'(r_vld), 32'h1);
        end
        rr_drv = 4'h0;
        tick();
        tick();
        check("r_drained", 32'(exp_r.size()), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
